// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state type, default operand widths, the step-counter width
// and the all-ones quotient returned on divide-by-zero.
// Optional build macro used by the divider: DIV_SELFCHECK_EN.
package div_pkg;

    // Default dividend/quotient width and divisor/remainder width.
    localparam int unsigned DW_DEF = 8;
    localparam int unsigned VW_DEF = 4;

    // Step counter counts DW-1 down to 0.
    localparam int unsigned CNT_W = $clog2(DW_DEF);

    // Quotient reported when the divisor is zero.
    localparam logic [DW_DEF-1:0] DZ_QUOT = {DW_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   pr_i      partial remainder (VW+1 bits, top bit is always 0 in use)
//   bit_i     next dividend bit shifted into the remainder
//   dv_i      divisor
//   pr_nxt_c  partial remainder after the trial subtraction
//   q_bit_c   quotient bit produced by this step
module div_step #(
    parameter int unsigned VW = 4
) (
    input  logic [VW:0]   pr_i,
    input  logic          bit_i,
    input  logic [VW-1:0] dv_i,
    output logic [VW:0]   pr_nxt_c,
    output logic          q_bit_c
);

    // One extra bit of headroom so the full incoming remainder takes part in
    // the compare; keeps the step correct even if pr_i[VW] were ever set.
    localparam int unsigned SW = VW + 2;

    logic [SW-1:0] sh_c;
    logic [SW-1:0] dv_ext_c;
    logic [SW-1:0] diff_c;

    // Shift, trial-subtract, restore on underflow.
    always_comb begin
        sh_c     = {pr_i, bit_i};
        dv_ext_c = SW'(dv_i);
        diff_c   = sh_c - dv_ext_c;
        q_bit_c  = (sh_c >= dv_ext_c);
        pr_nxt_c = q_bit_c ? (VW+1)'(diff_c) : (VW+1)'(sh_c);
    end

endmodule

// File: rtl/div8x4_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Accepts a DW-bit dividend and VW-bit divisor over a valid/ready handshake
// and returns a DW-bit quotient and VW-bit remainder over a second one.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   m, b                dividend, divisor
//   out_valid/out_ready result handshake
//   q, r                quotient, remainder (held until next result)
//   dz                  divide-by-zero flag, qualified by out_valid
//   chk_err             self-check mismatch, qualified by out_valid
// Build option: define DIV_SELFCHECK_EN to register a q*b+r==m check into
// chk_err and enable a simulation assertion; otherwise chk_err is tied 0.
module div8x4_seq
    import div_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] m,
    input  logic [VW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          dz,
    output logic          chk_err
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    state_e        state_q, state_d;
    logic [DW-1:0] sr_q, sr_d;      // dividend bits out, quotient bits in
    logic [VW-1:0] dv_q, dv_d;
    logic [VW:0]   pr_q, pr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] r_q, r_d;
    logic          dz_q, dz_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [VW:0]   pr_nxt_c;
    logic          q_bit_c;
    logic [DW-1:0] sr_shift_c;

    div_step #(.VW(VW)) u_step (
        .pr_i     (pr_q),
        .bit_i    (sr_q[DW-1]),
        .dv_i     (dv_q),
        .pr_nxt_c (pr_nxt_c),
        .q_bit_c  (q_bit_c)
    );

    assign sr_shift_c = {sr_q[DW-2:0], q_bit_c};

`ifdef DIV_SELFCHECK_EN
    localparam int unsigned PW = DW + VW;

    logic [DW-1:0] m_q, m_d;        // original dividend kept for the check
    logic          chk_q, chk_d;
    logic [PW-1:0] chk_prod_c;

    // Reconstruct the dividend from the result being committed to DONE.
    assign chk_prod_c = PW'(sr_shift_c) * PW'(dv_q) + PW'(pr_nxt_c[VW-1:0]);
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        dv_d    = dv_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
`ifdef DIV_SELFCHECK_EN
        m_d     = m_q;
        chk_d   = chk_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d  = m;
                    dv_d  = b;
                    pr_d  = '0;
                    cnt_d = CW'(DW - 1);
`ifdef DIV_SELFCHECK_EN
                    m_d   = m;
`endif
                    if (b == '0) begin
                        // Zero divisor skips the iteration entirely.
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = '0;
                        dz_d    = 1'b1;
`ifdef DIV_SELFCHECK_EN
                        chk_d   = 1'b0;
`endif
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                sr_d = sr_shift_c;
                pr_d = pr_nxt_c;
                if (cnt_q == '0) begin
                    // Result registers only move on entry to DONE.
                    state_d = DONE;
                    q_d     = sr_shift_c;
                    r_d     = pr_nxt_c[VW-1:0];
                    dz_d    = 1'b0;
`ifdef DIV_SELFCHECK_EN
                    chk_d   = (chk_prod_c != PW'(m_q));
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            dv_q        <= '0;
            pr_q        <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            dv_q        <= dv_d;
            pr_q        <= pr_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef DIV_SELFCHECK_EN
    // Self-check registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= '0;
            chk_q <= 1'b0;
        end else begin
            m_q   <= m_d;
            chk_q <= chk_d;
        end
    end

    assign chk_err = chk_q;

    // A delivered result must always satisfy q*b + r == m.
    a_selfcheck: assert property (@(posedge clk) disable iff (rst)
        !(out_valid && chk_err))
        else $error("div8x4_seq self-check: q*b+r != m");
`else
    assign chk_err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign r         = r_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_div8x4_seq.sv
// Bench for div8x4_seq: directed cases, exhaustive operand sweep and random
// operations with random backpressure, checked against plain arithmetic.
module tb_div8x4_seq;
    import div_pkg::*;

    localparam int unsigned DW = DW_DEF;
    localparam int unsigned VW = VW_DEF;
    localparam int          TIMEOUT = 64;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] m;
    logic [VW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    logic          chk_err;

    int n_checks = 0;
    int n_fail   = 0;

    div8x4_seq #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m         (m),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dz        (dz),
        .chk_err   (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain unsigned division, all-ones quotient on zero divisor.
    function automatic logic [DW-1:0] ref_q(input int mv, input int bv);
        return (bv == 0) ? DW'((1 << DW) - 1) : DW'(mv / bv);
    endfunction

    function automatic logic [VW-1:0] ref_r(input int mv, input int bv);
        return (bv == 0) ? '0 : VW'(mv % bv);
    endfunction

    // Full transaction; hold = cycles out_ready stays low after out_valid.
    task automatic run_op(input int mv, input int bv, input int hold);
        int k;
        int exp_lat;
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        eq      = ref_q(mv, bv);
        er      = ref_r(mv, bv);
        exp_lat = (bv == 0) ? 1 : DW + 1;

        k = 0;
        while (!in_ready && k < TIMEOUT) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("in_ready_before_accept", 32'(in_ready), 32'd1);

        @(negedge clk);
        in_valid  = 1'b1;
        m         = DW'(mv);
        b         = VW'(bv);
        out_ready = (hold == 0);
        @(posedge clk); #1;              // accept edge = cycle 0
        in_valid = 1'b0;

        k = 0;
        while (!out_valid && k < TIMEOUT) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid) begin
            check_val("out_valid_timeout", 32'(out_valid), 32'd1);
            return;
        end
        check_val("latency", 32'(k + 1), 32'(exp_lat));
        check_val("q", 32'(q), 32'(eq));
        check_val("r", 32'(r), 32'(er));
        check_val("dz", 32'(dz), 32'(bv == 0));
        check_val("chk_err", 32'(chk_err), 32'd0);
        check_val("in_ready_done", 32'(in_ready), 32'd0);

        // Result must stay put while the consumer stalls; also offer
        // conflicting operands that must be ignored.
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = (i == 0);
            m        = 8'd1;
            b        = 4'd1;
            @(posedge clk); #1;
            check_val("hold_valid", 32'(out_valid), 32'd1);
            check_val("hold_q", 32'(q), 32'(eq));
            check_val("hold_r", 32'(r), 32'(er));
            check_val("hold_in_ready", 32'(in_ready), 32'd0);
        end
        if (hold > 0) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        check_val("idle_out_valid", 32'(out_valid), 32'd0);
        check_val("idle_in_ready", 32'(in_ready), 32'd1);
        check_val("idle_q_held", 32'(q), 32'(eq));
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        m         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_q", 32'(q), 32'd0);
        check_val("rst_r", 32'(r), 32'd0);
        check_val("rst_dz", 32'(dz), 32'd0);
        check_val("rst_chk_err", 32'(chk_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op(143, 11, 0);
        run_op(200, 15, 0);
        run_op(5, 9, 0);
        run_op(255, 1, 0);
        run_op(7, 0, 0);
        run_op(100, 7, 5);
        run_op(0, 15, 0);
        run_op(255, 15, 0);

        // Reset during RUN aborts with no result.
        @(negedge clk);
        in_valid = 1'b1;
        m        = 8'd99;
        b        = 4'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("abort_in_ready", 32'(in_ready), 32'd1);
        check_val("abort_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_val("abort_no_result", 32'(seen), 32'd0);
        check_val("abort_idle", 32'(in_ready), 32'd1);
        run_op(99, 4, 0);

        // Exhaustive operand sweep.
        for (int mi = 0; mi < 256; mi++) begin
            for (int bi = 0; bi < 16; bi++) begin
                run_op(mi, bi, 0);
            end
        end

        // Random operations with random backpressure.
        for (int n = 0; n < 150; n++) begin
            run_op(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)),
                   int'($urandom_range(3, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
